// File: rtl/scalar_register_bank.sv
// Scalar register file: NUM_REGS x DATA_WIDTH flops, two combinational read ports, one write port.
// Optional same-cycle write-to-read forwarding is enabled by defining SCALAR_REG_BANK_BYPASS_EN.
`timescale 1ns/1ps
module scalar_register_bank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] ro1,
  output logic [DATA_WIDTH-1:0] ro2
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_sel;

  always_comb begin
    wr_sel = '0;
    if (write_enable) begin
      wr_sel[rd] = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        regs_q[g] <= '0;
      end else if (wr_sel[g]) begin
        regs_q[g] <= write_data;
      end
    end
  end

`ifdef SCALAR_REG_BANK_BYPASS_EN
  // rst gates the forward so reads show the cleared state while reset is held.
  logic fwd_ok;
  assign fwd_ok = write_enable && rst;

  always_comb begin
    ro1 = regs_q[rs1];
    ro2 = regs_q[rs2];
    if (fwd_ok && (rs1 == rd)) begin
      ro1 = write_data;
    end
    if (fwd_ok && (rs2 == rd)) begin
      ro2 = write_data;
    end
  end
`else
  always_comb begin
    ro1 = regs_q[rs1];
    ro2 = regs_q[rs2];
  end
`endif

endmodule

// File: tb/tb_scalar_register_bank.sv
// Self-checking bench for scalar_register_bank: directed scenarios plus randomized traffic
// checked against an array model of the register contents.
`timescale 1ns/1ps
module tb_scalar_register_bank;

`ifdef SCALAR_REG_BANK_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        write_enable;
  logic [1:0]  rs1, rs2, rd;
  logic [31:0] write_data;
  logic [31:0] ro1, ro2;

  logic [31:0] mdl [4];
  int checks = 0;
  int errors = 0;

  scalar_register_bank #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .write_enable(write_enable),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .write_data  (write_data),
    .ro1         (ro1),
    .ro2         (ro2)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  function automatic logic [31:0] expect_read(input logic [1:0] a);
    if (Bypass && write_enable && rst && (a == rd)) return write_data;
    return mdl[a];
  endfunction

  // Commit one write on the next rising edge; inputs change on the falling edge.
  task automatic do_write(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    write_enable = 1'b1;
    rd           = addr;
    write_data   = data;
    @(posedge clk);
    if (rst) mdl[addr] = data;
    #1;
    write_enable = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
  endtask

  task automatic test_reset();
    logic [1:0] a;
    for (int i = 0; i < 4; i++) begin
      a = i[1:0];
      do_write(a, $urandom() | 32'h1);
    end
    @(negedge clk);
    rs1 = 2'd2; rs2 = 2'd3;
    #1;
    checks++;
    if (ro1 !== mdl[2]) begin
      errors++; $display("FAIL preload_r2: got %h want %h", ro1, mdl[2]);
    end
    rst = 1'b0;
    clear_model();
    for (int i = 0; i < 4; i++) begin
      a = i[1:0];
      rs1 = a; rs2 = 2'd3 - a;
      #1;
      checks++;
      if (ro1 !== 32'h0 || ro2 !== 32'h0) begin
        errors++; $display("FAIL reset_read rs=%0d: got ro1=%h ro2=%h want 0", i, ro1, ro2);
      end
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    do_write(2'd0, 32'd54);
    do_write(2'd1, 32'd587);
    @(negedge clk);
    rs1 = 2'd0; rs2 = 2'd1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (ro1 !== 32'd54 || ro2 !== 32'd587) begin
        errors++; $display("FAIL basic_read cyc=%0d: got ro1=%0d ro2=%0d want 54 587", c, ro1, ro2);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_write_disable();
    @(negedge clk);
    write_enable = 1'b0; rd = 2'd2; write_data = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rs1 = 2'd2; rs2 = 2'd2;
    #1;
    checks++;
    if (ro1 !== 32'h0 || ro2 !== 32'h0) begin
      errors++; $display("FAIL write_disable: got ro1=%h ro2=%h want 0", ro1, ro2);
    end
  endtask

  task automatic test_dual_port();
    do_write(2'd3, 32'h12345678);
    @(negedge clk);
    rs1 = 2'd3; rs2 = 2'd3;
    #1;
    checks++;
    if (ro1 !== 32'h12345678 || ro2 !== 32'h12345678) begin
      errors++; $display("FAIL dual_port: got ro1=%h ro2=%h want 12345678", ro1, ro2);
    end
  endtask

  task automatic test_collision();
    logic [31:0] want;
    @(negedge clk);
    write_enable = 1'b1; rd = 2'd1; write_data = 32'd99; rs1 = 2'd1; rs2 = 2'd0;
    #1;
    want = Bypass ? 32'd99 : 32'd587;
    checks++;
    if (ro1 !== want) begin
      errors++; $display("FAIL collision_pre: got %0d want %0d", ro1, want);
    end
    checks++;
    if (ro2 !== 32'd54) begin
      errors++; $display("FAIL collision_other_port: got %0d want 54", ro2);
    end
    @(posedge clk);
    mdl[1] = 32'd99;
    #1;
    write_enable = 1'b0;
    #1;
    checks++;
    if (ro1 !== 32'd99) begin
      errors++; $display("FAIL collision_post: got %0d want 99", ro1);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] want;
    do_write(2'd0, 32'd7);
    @(negedge clk);
    write_enable = 1'b1; rd = 2'd0; write_data = 32'd5; rs1 = 2'd0; rs2 = 2'd1;
    #1;
    want = Bypass ? 32'd5 : 32'd7;
    checks++;
    if (ro1 !== want) begin
      errors++; $display("FAIL reset_mid_pre: got %0d want %0d", ro1, want);
    end
    #2;
    rst = 1'b0;
    clear_model();
    #1;
    checks++;
    if (ro1 !== 32'h0 || ro2 !== 32'h0) begin
      errors++; $display("FAIL reset_mid_async: got ro1=%0d ro2=%0d want 0", ro1, ro2);
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (ro1 !== 32'h0) begin
        errors++; $display("FAIL reset_mid_hold edge=%0d: got %0d want 0", c, ro1);
      end
    end
    @(negedge clk);
    write_enable = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (ro1 !== 32'h0) begin
      errors++; $display("FAIL reset_mid_release: got %0d want 0", ro1);
    end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      write_enable = ($urandom_range(0, 2) != 0);
      rd           = 2'($urandom_range(0, 3));
      write_data   = $urandom();
      rs1          = 2'($urandom_range(0, 3));
      rs2          = 2'($urandom_range(0, 3));
      #1;
      e1 = expect_read(rs1);
      e2 = expect_read(rs2);
      checks++;
      if (ro1 !== e1 || ro2 !== e2) begin
        errors++;
        $display("FAIL random_pre n=%0d: got ro1=%h ro2=%h want %h %h", n, ro1, ro2, e1, e2);
      end
      @(posedge clk);
      if (write_enable) mdl[rd] = write_data;
      #1;
      e1 = expect_read(rs1);
      e2 = expect_read(rs2);
      checks++;
      if (ro1 !== e1 || ro2 !== e2) begin
        errors++;
        $display("FAIL random_post n=%0d: got ro1=%h ro2=%h want %h %h", n, ro1, ro2, e1, e2);
      end
    end
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  initial begin
    rst = 1'b0; write_enable = 1'b0;
    rs1 = 2'd0; rs2 = 2'd0; rd = 2'd0; write_data = 32'h0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ro1 !== 32'h0 || ro2 !== 32'h0) begin
      errors++; $display("FAIL initial_reset: got ro1=%h ro2=%h want 0", ro1, ro2);
    end
    @(negedge clk);
    rst = 1'b1;

    test_reset();
    test_basic();
    test_write_disable();
    test_dual_port();
    test_collision();
    test_reset_mid();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
